// File: rtl/multichannel_clk_phase_delay.sv
// Multi-channel slow-clock edge delayer: each channel synchronises its slow clock into
// fast_clk and reproduces it with programmable rise (and optionally fall) edge delays.
module multichannel_clk_phase_delay #(
    parameter int unsigned NUM_CHANNELS       = 4,
    parameter int unsigned NUM_BITS_DELAY     = 8,
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned DELAY_FALLING_EDGE = 0,
    parameter int unsigned RESET_DELAY        = 10
) (
    input  logic                                   fast_clk,
    input  logic                                   reset,
    input  logic [NUM_CHANNELS-1:0]                slow_clk,
    input  logic [NUM_CHANNELS*NUM_BITS_DELAY-1:0] rise_delay,
    input  logic [NUM_CHANNELS*NUM_BITS_DELAY-1:0] fall_delay,
    input  logic                                   delay_load,
    output logic [NUM_CHANNELS-1:0]                delayed_slow_clk,
    output logic [NUM_CHANNELS-1:0]                rise_pending,
    output logic [NUM_CHANNELS-1:0]                edge_dropped
);

    localparam int unsigned DW = NUM_BITS_DELAY;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_WAIT = 2'd3
    } state_e;

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s_prev_q;
        logic                   s;
        logic                   rise;
        logic                   fall;
        logic [DW-1:0]          rise_sh_q;
        logic [DW-1:0]          fall_sh_q;
        logic [DW-1:0]          tgt_q;
        logic [DW-1:0]          tgt_d;
        logic [DW-1:0]          cnt_q;
        logic [DW-1:0]          cnt_d;
        state_e                 state_q;
        state_e                 state_d;
        logic                   out_q;
        logic                   out_d;
        logic                   pend_q;
        logic                   drop_q;
        logic                   drop_d;

        assign s    = sync_q[SYNC_STAGES-1];
        assign rise = s & ~s_prev_q;
        assign fall = ~s & s_prev_q;

        // Input synchroniser, edge-detect history and shadow delay registers
        always_ff @(posedge fast_clk or posedge reset) begin
            if (reset) begin
                sync_q    <= '0;
                s_prev_q  <= 1'b0;
                rise_sh_q <= DW'(RESET_DELAY);
                fall_sh_q <= DW'(RESET_DELAY);
            end else begin
                sync_q   <= {sync_q[SYNC_STAGES-2:0], slow_clk[ch]};
                s_prev_q <= s;
                if (delay_load) begin
                    rise_sh_q <= rise_delay[ch*DW +: DW];
                    fall_sh_q <= fall_delay[ch*DW +: DW];
                end
            end
        end

        // State, counter, target and registered outputs
        always_ff @(posedge fast_clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_LOW;
                cnt_q   <= '0;
                tgt_q   <= '0;
                out_q   <= 1'b0;
                pend_q  <= 1'b0;
                drop_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                tgt_q   <= tgt_d;
                out_q   <= out_d;
                pend_q  <= (state_d == ST_RISE_WAIT);
                drop_q  <= drop_d;
            end
        end

        // Next-state logic; the level check precedes terminal count so short pulses drop
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            tgt_d   = tgt_q;
            out_d   = out_q;
            drop_d  = 1'b0;
            case (state_q)
                ST_LOW: begin
                    if (rise) begin
                        if (rise_sh_q == '0) begin
                            state_d = ST_HIGH;
                            out_d   = 1'b1;
                        end else begin
                            state_d = ST_RISE_WAIT;
                            cnt_d   = DW'(1);
                            tgt_d   = rise_sh_q;
                        end
                    end
                end
                ST_RISE_WAIT: begin
                    if (!s) begin
                        state_d = ST_LOW;
                        out_d   = 1'b0;
                        drop_d  = 1'b1;
                        cnt_d   = '0;
                    end else if (cnt_q == tgt_q) begin
                        state_d = ST_HIGH;
                        out_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        if ((DELAY_FALLING_EDGE == 0) || (fall_sh_q == '0)) begin
                            state_d = ST_LOW;
                            out_d   = 1'b0;
                        end else begin
                            state_d = ST_FALL_WAIT;
                            cnt_d   = DW'(1);
                            tgt_d   = fall_sh_q;
                        end
                    end
                end
                ST_FALL_WAIT: begin
                    if (s) begin
                        state_d = ST_HIGH;
                        out_d   = 1'b1;
                        drop_d  = 1'b1;
                        cnt_d   = '0;
                    end else if (cnt_q == tgt_q) begin
                        state_d = ST_LOW;
                        out_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    out_d   = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end

        assign delayed_slow_clk[ch] = out_q;
        assign rise_pending[ch]     = pend_q;
        assign edge_dropped[ch]     = drop_q;
    end

endmodule

// File: tb/tb_multichannel_clk_phase_delay.sv
// Scoreboard bench for multichannel_clk_phase_delay: one instance with undelayed falling
// edges, one with delayed falling edges; output transitions are matched against queued expectations.
module tb_multichannel_clk_phase_delay;

    logic        fast_clk = 1'b0;
    logic        reset;
    logic [3:0]  slow;
    logic [3:0]  slow_f;
    logic [31:0] rd;
    logic [31:0] fd;
    logic [31:0] rd_f;
    logic [31:0] fd_f;
    logic        load;
    logic        load_f;
    logic [3:0]  dly;
    logic [3:0]  pend;
    logic [3:0]  drop;
    logic [3:0]  dly_f;
    logic [3:0]  pend_f;
    logic [3:0]  drop_f;
    logic [7:0]  all_out;
    logic [7:0]  all_pend;
    logic [7:0]  all_drop;
    logic [7:0]  prv_out  = 8'h00;
    logic [7:0]  prv_pend = 8'h00;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    // kind*8 + idx; kinds: 0 output, 1 rise_pending, 2 edge_dropped; idx 4..7 = falling-delay instance
    int exp_q[24][$];

    multichannel_clk_phase_delay #(
        .NUM_CHANNELS(4), .NUM_BITS_DELAY(8), .SYNC_STAGES(2),
        .DELAY_FALLING_EDGE(0), .RESET_DELAY(10)
    ) dut (
        .fast_clk(fast_clk), .reset(reset), .slow_clk(slow),
        .rise_delay(rd), .fall_delay(fd), .delay_load(load),
        .delayed_slow_clk(dly), .rise_pending(pend), .edge_dropped(drop)
    );

    multichannel_clk_phase_delay #(
        .NUM_CHANNELS(4), .NUM_BITS_DELAY(8), .SYNC_STAGES(2),
        .DELAY_FALLING_EDGE(1), .RESET_DELAY(10)
    ) dut_f (
        .fast_clk(fast_clk), .reset(reset), .slow_clk(slow_f),
        .rise_delay(rd_f), .fall_delay(fd_f), .delay_load(load_f),
        .delayed_slow_clk(dly_f), .rise_pending(pend_f), .edge_dropped(drop_f)
    );

    always #5 fast_clk = ~fast_clk;
    always @(posedge fast_clk) cyc <= cyc + 1;

    assign all_out  = {dly_f, dly};
    assign all_pend = {pend_f, pend};
    assign all_drop = {drop_f, drop};

    function automatic void push_ev(int kind, int idx, int at, int val);
        exp_q[kind*8+idx].push_back(at*2 + val);
    endfunction

    // Input driven at negedge n: E0 = n+2, output changes at E0+D+1
    function automatic void exp_rise(int idx, int n, int d);
        if (d == 0) begin
            push_ev(0, idx, n + 3, 1);
        end else begin
            push_ev(1, idx, n + 3, 1);
            push_ev(1, idx, n + d + 3, 0);
            push_ev(0, idx, n + d + 3, 1);
        end
    endfunction

    function automatic void exp_fall(int idx, int m);
        push_ev(0, idx, m + 3, 0);
    endfunction

    function automatic void check_ev(int kind, int idx, int val);
        int key;
        int want;
        string kname;
        kname = (kind == 0) ? "out" : ((kind == 1) ? "pend" : "drop");
        key = cyc*2 + val;
        if (exp_q[kind*8+idx].size() > 0) want = exp_q[kind*8+idx].pop_front();
        else want = -2;
        tests++;
        assert (key === want) else begin
            fails++;
            $error("FAIL %s[%0d]: observed cyc=%0d lvl=%0d, expected cyc=%0d lvl=%0d",
                   kname, idx, key/2, key%2, want/2, want%2);
        end
    endfunction

    function automatic void chk4(string tag, logic [3:0] obs, logic [3:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endfunction

    // Output monitor: every transition / drop pulse must match the head of its queue
    always @(negedge fast_clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                if (all_out[i] !== prv_out[i]) check_ev(0, i, int'(all_out[i]));
                if (all_pend[i] !== prv_pend[i]) check_ev(1, i, int'(all_pend[i]));
                if (all_drop[i] !== 1'b0) check_ev(2, i, 1);
            end
        end
        prv_out  <= all_out;
        prv_pend <= all_pend;
    end

    task automatic step(int k);
        repeat (k) @(negedge fast_clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 24; i++) begin
            tests++;
            assert (exp_q[i].size() === 0) else begin
                fails++;
                $error("FAIL drain q%0d: observed %0d outstanding events, expected 0", i, exp_q[i].size());
            end
            exp_q[i].delete();
        end
    endtask

    task automatic load_main(logic [31:0] r, logic [31:0] f);
        rd = r; fd = f; load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic load_fast(logic [31:0] r, logic [31:0] f);
        rd_f = r; fd_f = f; load_f = 1'b1;
        step(1);
        load_f = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; slow = 4'b0001; slow_f = 4'b0000;
        rd = '0; fd = '0; rd_f = '0; fd_f = '0; load = 1'b0; load_f = 1'b0;
        step(3);
        chk4("rst_out", dly, 4'b0000);
        chk4("rst_pend", pend, 4'b0000);
        chk4("rst_drop", drop, 4'b0000);
        chk4("rst_out_f", dly_f, 4'b0000);
        chk4("rst_pend_f", pend_f, 4'b0000);
        chk4("rst_drop_f", drop_f, 4'b0000);

        // Release with ch0 high: fresh rise using RESET_DELAY=10
        reset = 1'b0;
        exp_rise(0, cyc, 10);
        step(20);
        slow[0] = 1'b0; exp_fall(0, cyc);
        step(8); drain();

        // Rise delay 3, long pulse, undelayed fall
        load_main({8'd255, 8'd5, 8'd3, 8'd0}, 32'h0);
        step(2);
        slow[1] = 1'b1; exp_rise(1, cyc, 3);
        step(50);
        slow[1] = 1'b0; exp_fall(1, cyc);
        step(6); drain();

        // Delay 5: 4-cycle pulse dropped, 6-cycle pulse propagates
        n = cyc;
        slow[2] = 1'b1;
        push_ev(1, 2, n + 3, 1); push_ev(1, 2, n + 7, 0); push_ev(2, 2, n + 7, 1);
        step(4);
        slow[2] = 1'b0;
        step(10); drain();
        slow[2] = 1'b1; exp_rise(2, cyc, 5);
        step(6);
        slow[2] = 1'b0; exp_fall(2, cyc);
        step(8); drain();

        // Boundary delays 0 and 255
        slow[0] = 1'b1; exp_rise(0, cyc, 0);
        slow[3] = 1'b1; exp_rise(3, cyc, 255);
        step(10);
        slow[0] = 1'b0; exp_fall(0, cyc);
        step(260);
        slow[3] = 1'b0; exp_fall(3, cyc);
        step(6); drain();

        // Load 7 -> 2 mid-count: in-flight count finishes at 7, next edge uses 2
        load_main({8'd255, 8'd5, 8'd7, 8'd0}, 32'h0);
        step(2);
        slow[1] = 1'b1; exp_rise(1, cyc, 7);
        step(5);
        load_main({8'd255, 8'd5, 8'd2, 8'd0}, 32'h0);
        step(14);
        slow[1] = 1'b0; exp_fall(1, cyc);
        step(10);
        slow[1] = 1'b1; exp_rise(1, cyc, 2);
        step(10);
        slow[1] = 1'b0; exp_fall(1, cyc);
        step(6); drain();

        // Load on the detection edge: edge keeps old value 2, next edge uses 6
        slow[1] = 1'b1; exp_rise(1, cyc, 2);
        step(2);
        load_main({8'd255, 8'd5, 8'd6, 8'd0}, 32'h0);
        step(12);
        slow[1] = 1'b0; exp_fall(1, cyc);
        step(10);
        slow[1] = 1'b1; exp_rise(1, cyc, 6);
        step(15);
        slow[1] = 1'b0; exp_fall(1, cyc);
        step(6); drain();

        // All channels concurrently with distinct delays
        load_main({8'd2, 8'd9, 8'd4, 8'd1}, 32'h0);
        step(2);
        slow[0] = 1'b1; exp_rise(0, cyc, 1);
        slow[1] = 1'b1; exp_rise(1, cyc, 4);
        step(1);
        slow[2] = 1'b1; exp_rise(2, cyc, 9);
        step(1);
        slow[3] = 1'b1; exp_rise(3, cyc, 2);
        step(18);
        slow[0] = 1'b0; exp_fall(0, cyc);
        step(1);
        slow[1] = 1'b0; exp_fall(1, cyc);
        step(1);
        slow[2] = 1'b0; exp_fall(2, cyc);
        step(1);
        slow[3] = 1'b0; exp_fall(3, cyc);
        step(6); drain();

        // Falling-delay instance, ch3: rise 1, fall 2
        load_fast({8'd1, 8'd0, 8'd0, 8'd0}, {8'd2, 8'd0, 8'd0, 8'd0});
        step(2);
        slow_f[3] = 1'b1; exp_rise(7, cyc, 1);
        step(20);
        n = cyc;
        slow_f[3] = 1'b0;
        push_ev(2, 7, n + 4, 1);
        step(1);
        slow_f[3] = 1'b1;
        step(9);
        n = cyc;
        slow_f[3] = 1'b0;
        push_ev(0, 7, n + 5, 0);
        step(3);
        slow_f[3] = 1'b1;
        push_ev(1, 7, n + 6, 1); push_ev(1, 7, n + 7, 0); push_ev(0, 7, n + 7, 1);
        step(12);
        n = cyc;
        slow_f[3] = 1'b0;
        push_ev(0, 7, n + 5, 0);
        step(8); drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
